load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 16: request byte-address width and MemAdresa width.
REQ-002 Parameter DATA_W, default 16: data width; only 16 is supported.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 ReqValid  input  1  request present.
REQ-006 ReqReady  output  1  unit can accept a request.
REQ-007 ReqWrite  input  1  1 = store, 0 = load.
REQ-008 ReqByte  input  1  1 = byte access, 0 = word access.
REQ-009 ReqSigned  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 ReqAddr  input  16  byte address.
REQ-011 ReqWData  input  16  store data; a byte store uses bits [7:0].
REQ-012 RespValid  output  1  one-cycle completion pulse.
REQ-013 RespData  output  16  load result; 0 for stores and errors.
REQ-014 RespErr  output  1  misaligned word access; valid with RespValid.
REQ-015 MemAdresa  output  16  word address to DataMemory.
REQ-016 MemWD  output  16  write data to DataMemory.
REQ-017 MemWrite  output  1  DataMemory write strobe; DataMemory writes on the rising edge.
REQ-018 MemRead  output  1  DataMemory read enable.
REQ-019 MemReadData  input  16  DataMemory read data, combinationally valid while MemRead is high.

Function
REQ-020 The FSM SHALL have states IDLE, RD, WR, RMW_RD, RMW_WR and RESP.
REQ-021 ReqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge with ReqValid=1 in IDLE, and all request fields SHALL be registered at that edge.
REQ-022 Transitions from IDLE on accept: misaligned (ReqByte=0 and ReqAddr[0]=1) -> RESP; word or byte load -> RD; word store -> WR; byte store -> RMW_RD.
REQ-023 RD->RESP; WR->RESP; RMW_RD->RMW_WR; RMW_WR->RESP; RESP->IDLE. Each of these states SHALL last exactly one cycle.
REQ-024 MemAdresa SHALL be {1'b0, addr[15:1]} throughout RD, WR, RMW_RD and RMW_WR, and SHALL hold its last value elsewhere.
REQ-025 MemRead SHALL be 1 only in RD and RMW_RD; MemWrite SHALL be 1 only in WR and RMW_WR; the two SHALL never be 1 together.
REQ-026 MemReadData SHALL be captured at the rising edge that ends RD or RMW_RD.
REQ-027 Byte lanes: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8].
REQ-028 Byte load: RespData = selected byte, extended per ReqSigned. Word load: RespData = captured word.
REQ-029 Byte store: in RMW_WR, MemWD = captured word with only the selected lane replaced by ReqWData[7:0]. Word store: in WR, MemWD = ReqWData.
REQ-030 RespValid SHALL be 1 exactly in RESP. Latency from the accepting edge: loads 2 cycles, word stores 2 cycles, byte stores 3 cycles, misaligned 1 cycle.
REQ-031 A misaligned request SHALL cause no MemRead or MemWrite assertion; it returns RespErr=1 and RespData=0.
REQ-032 RespErr and RespData SHALL be 0 whenever RespValid=0.
REQ-033 A request is honoured at the earliest on the edge that ends the RESP-to-IDLE cycle, giving a 3-cycle minimum spacing for loads and word stores. ReqValid outside IDLE SHALL be ignored.
REQ-034 Address 16'hFFFF as a byte access SHALL map to word 16'h7FFF with the upper lane; there is no wrap error.

Reset
REQ-035 Reset=1 SHALL immediately force state IDLE and set ReqReady=0, RespValid=0, RespData=0, RespErr=0, MemRead=0, MemWrite=0, MemAdresa=0, MemWD=0; ReqReady becomes 1 in IDLE after reset is released.
REQ-036 Reset asserted mid-operation SHALL abort it: MemWrite drops asynchronously, no response is issued, and a partly done byte store leaves memory unchanged if reset arrives before the RMW_WR edge.

Structure
REQ-037 Shared package lsu_pkg SHALL hold the state encoding (3-bit localparams), the lane-select constants and the data-width constant.
REQ-038 Byte extract and merge logic SHALL be the combinational sub-module byte_lane_unit; the FSM stays in load_store_unit.

Verification
REQ-039 Word store addr 16'h0014, data 16'h1234 -> MemWrite for one cycle with MemAdresa=16'h000A, MemWD=16'h1234; RespValid 2 cycles after accept.
REQ-040 Byte store addr 16'h0015, data 16'h00AB over stored word 16'h1234 -> RMW writes MemWD=16'hAB34; a later word load from 16'h0014 returns 16'hAB34.
REQ-041 Signed byte load from 16'h0015 (word 16'hAB34) -> RespData=16'hFFAB; unsigned load -> 16'h00AB; addr 16'h0014 unsigned -> 16'h0034.
REQ-042 Word load from 16'h0013 -> RespValid with RespErr=1 and RespData=0 one cycle after accept; MemRead and MemWrite stay 0.
REQ-043 Reset asserted during RMW_RD of a byte store -> MemWrite is never asserted, memory is unchanged, no RespValid is issued, and ReqReady=1 after release.
REQ-044 Back-to-back requests with ReqValid held high -> the second request is accepted exactly 3 cycles after the first (load) and ReqReady=0 in between.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, byte-lane selects
// and the supported data width.
package lsu_pkg;

  localparam int unsigned LsuDataW = 16;

  localparam logic [2:0] EncIdle  = 3'd0;
  localparam logic [2:0] EncRd    = 3'd1;
  localparam logic [2:0] EncWr    = 3'd2;
  localparam logic [2:0] EncRmwRd = 3'd3;
  localparam logic [2:0] EncRmwWr = 3'd4;
  localparam logic [2:0] EncResp  = 3'd5;

  typedef enum logic [2:0] {
    StIdle  = EncIdle,
    StRd    = EncRd,
    StWr    = EncWr,
    StRmwRd = EncRmwRd,
    StRmwWr = EncRmwWr,
    StResp  = EncResp
  } lsu_state_e;

  // Byte address bit 0 picks the lane within a 16-bit word.
  localparam logic LaneLo = 1'b0;
  localparam logic LaneHi = 1'b1;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte extraction (with sign/zero extension) and byte merge
// into a 16-bit word.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [LsuDataW-1:0] word_i,
  input  logic                lane_i,
  input  logic                signed_i,
  input  logic [7:0]          wbyte_i,
  output logic [LsuDataW-1:0] load_o,
  output logic [LsuDataW-1:0] merged_o
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = (lane_i == LaneHi) ? word_i[15:8] : word_i[7:0];
    load_o   = signed_i ? {{8{sel_byte[7]}}, sel_byte} : {8'h00, sel_byte};
    merged_o = word_i;
    if (lane_i == LaneHi) begin
      merged_o[15:8] = wbyte_i;
    end else begin
      merged_o[7:0] = wbyte_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word and byte accesses to a 16-bit
// DataMemory, byte stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = LsuDataW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic              ReqByte,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RespValid,
  output logic [DATA_W-1:0] RespData,
  output logic              RespErr,
  output logic [ADDR_W-1:0] MemAdresa,
  output logic [DATA_W-1:0] MemWD,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  lsu_state_e        state_q, state_d;
  logic              write_q, byte_q, signed_q, lane_q, err_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [ADDR_W-1:0] mem_adr_q;

  logic              accept, misaligned;
  logic [DATA_W-1:0] load_byte, merged_word;

  assign misaligned = ~ReqByte & ReqAddr[0];
  assign accept     = (state_q == StIdle) & ReqValid;
  assign MemAdresa  = mem_adr_q;

  byte_lane_unit u_byte_lane (
    .word_i   (rdata_q),
    .lane_i   (lane_q),
    .signed_i (signed_q),
    .wbyte_i  (wdata_q[7:0]),
    .load_o   (load_byte),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d   = state_q;
    ReqReady  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemWD     = '0;
    RespValid = 1'b0;
    RespErr   = 1'b0;
    RespData  = '0;
    unique case (state_q)
      StIdle: begin
        ReqReady = ~Reset;
        if (ReqValid) begin
          if (misaligned)     state_d = StResp;
          else if (!ReqWrite) state_d = StRd;
          else if (!ReqByte)  state_d = StWr;
          else                state_d = StRmwRd;
        end
      end
      StRd: begin
        MemRead = 1'b1;
        state_d = StResp;
      end
      StWr: begin
        MemWrite = 1'b1;
        MemWD    = wdata_q;
        state_d  = StResp;
      end
      StRmwRd: begin
        MemRead = 1'b1;
        state_d = StRmwWr;
      end
      StRmwWr: begin
        MemWrite = 1'b1;
        MemWD    = merged_word;
        state_d  = StResp;
      end
      StResp: begin
        RespValid = 1'b1;
        RespErr   = err_q;
        if (!write_q && !err_q) begin
          RespData = byte_q ? load_byte : rdata_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      byte_q    <= 1'b0;
      signed_q  <= 1'b0;
      lane_q    <= LaneLo;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_adr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= ReqWrite;
        byte_q   <= ReqByte;
        signed_q <= ReqSigned;
        lane_q   <= ReqAddr[0];
        err_q    <= misaligned;
        wdata_q  <= ReqWData;
        // A rejected access never touches memory, so the address bus keeps its old value.
        if (!misaligned) begin
          mem_adr_q <= {1'b0, ReqAddr[ADDR_W-1:1]};
        end
      end
      if (state_q == StRd || state_q == StRmwRd) begin
        rdata_q <= MemReadData;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural DataMemory and a
// response scoreboard.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqReady, ReqWrite, ReqByte, ReqSigned;
  logic [15:0] ReqAddr, ReqWData;
  logic        RespValid, RespErr;
  logic [15:0] RespData, MemAdresa, MemWD, MemReadData;
  logic        MemWrite, MemRead;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [15:0] mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a;
  logic [15:0] poke_d;

  int          lat, nrd, nwr;
  logic [15:0] rd, wadr, wwd;
  logic        er, both;

  always #5 Clock = ~Clock;

  assign MemReadData = MemRead ? mem[MemAdresa[7:0]] : 16'hDEAD;

  always @(posedge Clock) begin
    if (poke_en)       mem[poke_a] <= poke_d;
    else if (MemWrite) mem[MemAdresa[7:0]] <= MemWD;
  end

  load_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqWrite    (ReqWrite),
    .ReqByte     (ReqByte),
    .ReqSigned   (ReqSigned),
    .ReqAddr     (ReqAddr),
    .ReqWData    (ReqWData),
    .RespValid   (RespValid),
    .RespData    (RespData),
    .RespErr     (RespErr),
    .MemAdresa   (MemAdresa),
    .MemWD       (MemWD),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemReadData (MemReadData)
  );

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge Clock);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    @(posedge Clock);
    #1 poke_en = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic er_i, input int l);
    exp_t x;
    x.data = d;
    x.err  = er_i;
    x.lat  = l;
    sb.push_back(x);
  endtask

  // Drives one request and records the DUT activity up to its response; lat stays 0 without one.
  task automatic drive_req(input logic w, input logic b, input logic s,
                           input logic [15:0] a, input logic [15:0] wd);
    int guard = 0;
    lat = 0; rd = 0; er = 0; nrd = 0; nwr = 0; wadr = 0; wwd = 0; both = 0;
    @(negedge Clock);
    while (!ReqReady && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    ReqValid = 1'b1; ReqWrite = w; ReqByte = b; ReqSigned = s; ReqAddr = a; ReqWData = wd;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clock);
      if (MemRead) nrd++;
      if (MemWrite) begin
        nwr++;
        wadr = MemAdresa;
        wwd  = MemWD;
      end
      if (MemRead && MemWrite) both = 1'b1;
      if (RespValid) begin
        lat = c;
        rd  = RespData;
        er  = RespErr;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0; ReqSigned = 1'b0;
    ReqAddr = '0; ReqWData = '0;
    #2;
    n_checks++;
    if ({ReqReady, RespValid, RespData, RespErr, MemRead, MemWrite, MemAdresa, MemWD} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rdata=%h err=%b rd=%b wr=%b adr=%h wd=%h, want all 0",
               ReqReady, RespValid, RespData, RespErr, MemRead, MemWrite, MemAdresa, MemWD);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", ReqReady);
    end
  endtask

  task automatic test_word_store;
    push_exp(16'h0000, 1'b0, 2);
    drive_req(1'b1, 1'b0, 1'b0, 16'h0014, 16'h1234);
    e = sb.pop_front();
    n_checks++;
    if ({lat, rd, er} !== {e.lat, e.data, e.err}) begin
      n_fail++;
      $display("FAIL word_store_resp: lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
               lat, rd, er, e.lat, e.data, e.err);
    end
    n_checks++;
    if ({nwr, nrd, wadr, wwd} !== {32'd1, 32'd0, 16'h000A, 16'h1234}) begin
      n_fail++;
      $display("FAIL word_store_mem: nwr=%0d nrd=%0d adr=%h wd=%h want 1 0 000a 1234",
               nwr, nrd, wadr, wwd);
    end
  endtask

  task automatic test_byte_store;
    push_exp(16'h0000, 1'b0, 3);
    drive_req(1'b1, 1'b1, 1'b0, 16'h0015, 16'h00AB);
    e = sb.pop_front();
    n_checks++;
    if ({lat, rd, er} !== {e.lat, e.data, e.err}) begin
      n_fail++;
      $display("FAIL byte_store_resp: lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
               lat, rd, er, e.lat, e.data, e.err);
    end
    n_checks++;
    if ({nrd, nwr, wadr, wwd, both} !== {32'd1, 32'd1, 16'h000A, 16'hAB34, 1'b0}) begin
      n_fail++;
      $display("FAIL byte_store_rmw: nrd=%0d nwr=%0d adr=%h wd=%h both=%b want 1 1 000a ab34 0",
               nrd, nwr, wadr, wwd, both);
    end
    push_exp(16'hAB34, 1'b0, 2);
    drive_req(1'b0, 1'b0, 1'b0, 16'h0014, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if ({lat, rd, er} !== {e.lat, e.data, e.err}) begin
      n_fail++;
      $display("FAIL word_load_after_rmw: lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
               lat, rd, er, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_byte_loads;
    logic [15:0] addrs [4];
    logic        sgn   [4];
    logic [15:0] want  [4];
    addrs = '{16'h0015, 16'h0015, 16'h0014, 16'h0014};
    sgn   = '{1'b1, 1'b0, 1'b0, 1'b1};
    want  = '{16'hFFAB, 16'h00AB, 16'h0034, 16'h0034};
    for (int i = 0; i < 4; i++) begin
      push_exp(want[i], 1'b0, 2);
      drive_req(1'b0, 1'b1, sgn[i], addrs[i], 16'hFFFF);
      e = sb.pop_front();
      n_checks++;
      if ({lat, rd, er, nrd, nwr} !== {e.lat, e.data, e.err, 32'd1, 32'd0}) begin
        n_fail++;
        $display("FAIL byte_load_%0d: lat=%0d data=%h err=%b nrd=%0d nwr=%0d want lat=%0d data=%h err=0 nrd=1 nwr=0",
                 i, lat, rd, er, nrd, nwr, e.lat, e.data);
      end
    end
  endtask

  task automatic test_misaligned;
    push_exp(16'h0000, 1'b1, 1);
    drive_req(1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if ({lat, rd, er, nrd, nwr} !== {e.lat, e.data, e.err, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL misaligned_load: lat=%0d data=%h err=%b nrd=%0d nwr=%0d want lat=1 data=0 err=1 no mem",
               lat, rd, er, nrd, nwr);
    end
    push_exp(16'h0000, 1'b1, 1);
    drive_req(1'b1, 1'b0, 1'b0, 16'h0015, 16'hFFFF);
    e = sb.pop_front();
    n_checks++;
    if ({lat, rd, er, nrd, nwr} !== {e.lat, e.data, e.err, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL misaligned_store: lat=%0d data=%h err=%b nrd=%0d nwr=%0d want lat=1 data=0 err=1 no mem",
               lat, rd, er, nrd, nwr);
    end
    n_checks++;
    if (mem[8'h0A] !== 16'hAB34) begin
      n_fail++;
      $display("FAIL misaligned_mem_untouched: got %h want ab34", mem[8'h0A]);
    end
  endtask

  task automatic test_top_addr;
    poke(8'hFF, 16'h8012);
    push_exp(16'hFF80, 1'b0, 2);
    drive_req(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if ({lat, rd, er} !== {e.lat, e.data, e.err}) begin
      n_fail++;
      $display("FAIL top_byte_load: lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
               lat, rd, er, e.lat, e.data, e.err);
    end
    push_exp(16'h0000, 1'b0, 3);
    drive_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h553C);
    e = sb.pop_front();
    n_checks++;
    if ({lat, er, wadr, wwd} !== {e.lat, e.err, 16'h7FFF, 16'h3C12}) begin
      n_fail++;
      $display("FAIL top_byte_store: lat=%0d err=%b adr=%h wd=%h want lat=3 err=0 adr=7fff wd=3c12",
               lat, er, wadr, wwd);
    end
  endtask

  task automatic test_reset_midop;
    logic saw_wr, saw_rv;
    poke(8'h20, 16'h5566);
    poke(8'h21, 16'h1111);
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b1; ReqSigned = 1'b0;
    ReqAddr = 16'h0041; ReqWData = 16'h0077;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    n_checks++;
    if (MemRead !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_in_rmw_rd: MemRead=%b want 1", MemRead);
    end
    #1 Reset = 1'b1;
    #1;
    n_checks++;
    if ({MemRead, MemWrite, RespValid, ReqReady} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: rd=%b wr=%b rv=%b rdy=%b want 0000",
               MemRead, MemWrite, RespValid, ReqReady);
    end
    saw_wr = 1'b0;
    saw_rv = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      saw_wr |= MemWrite;
      saw_rv |= RespValid;
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_ready_after_release: got %b want 1", ReqReady);
    end
    repeat (4) begin
      @(negedge Clock);
      saw_wr |= MemWrite;
      saw_rv |= RespValid;
    end
    n_checks++;
    if ({saw_wr, saw_rv, mem[8'h20]} !== {1'b0, 1'b0, 16'h5566}) begin
      n_fail++;
      $display("FAIL midop_rmw_abort: sawwr=%b sawrv=%b mem=%h want 0 0 5566", saw_wr, saw_rv, mem[8'h20]);
    end
    // Abort a word store while its write strobe is high.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b0; ReqAddr = 16'h0042; ReqWData = 16'h9999;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    #1 Reset = 1'b1;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_wr_async_drop: MemWrite=%b want 0", MemWrite);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    n_checks++;
    if (mem[8'h21] !== 16'h1111) begin
      n_fail++;
      $display("FAIL midop_wr_mem: got %h want 1111", mem[8'h21]);
    end
  endtask

  task automatic test_back_to_back;
    int   acc[$];
    logic rdy [10];
    logic [15:0] resp[$];
    int   guard = 0;
    push_exp(16'hAB34, 1'b0, 0);
    push_exp(16'hFFAB, 1'b0, 0);
    @(negedge Clock);
    while (!ReqReady && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqByte = 1'b0; ReqSigned = 1'b0; ReqAddr = 16'h0014;
    for (int c = 0; c < 10; c++) begin
      rdy[c] = ReqReady;
      if (RespValid) resp.push_back(RespData);
      if (ReqReady && ReqValid) acc.push_back(c);
      @(posedge Clock);
      #1;
      if (acc.size() == 1 && acc[0] == c) begin
        ReqByte = 1'b1; ReqSigned = 1'b1; ReqAddr = 16'h0015;
      end
      if (acc.size() == 2) ReqValid = 1'b0;
      @(negedge Clock);
    end
    n_checks++;
    if (acc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_accept_count: got %0d want 2", acc.size());
    end else begin
      n_checks++;
      if (acc[1] - acc[0] != 3) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d want 3", acc[1] - acc[0]);
      end
      n_checks++;
      if ({rdy[acc[0]+1], rdy[acc[0]+2]} !== 2'b00) begin
        n_fail++;
        $display("FAIL b2b_ready_gap: got %b want 00", {rdy[acc[0]+1], rdy[acc[0]+2]});
      end
    end
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_checks++;
      if (resp.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_resp_%0d: got no response want %h", i, e.data);
      end else begin
        rd = resp.pop_front();
        if (rd !== e.data) begin
          n_fail++;
          $display("FAIL b2b_resp_%0d: got %h want %h", i, rd, e.data);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] sh [16];
    logic [15:0] d, a, w;
    logic [7:0]  bt;
    int          op, wi;
    logic        lane, s;
    for (int i = 0; i < 16; i++) begin
      sh[i] = 16'($urandom);
      poke(8'h30 + 8'(i), sh[i]);
    end
    for (int i = 0; i < 12; i++) begin
      op   = $urandom_range(0, 3);
      wi   = $urandom_range(0, 15);
      lane = 1'($urandom_range(0, 1));
      s    = 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      w    = sh[wi];
      a    = ((16'h0030 + 16'(wi)) << 1) | ((op == 1 || op == 3) ? {15'd0, lane} : 16'd0);
      bt   = lane ? w[15:8] : w[7:0];
      case (op)
        0: begin push_exp(16'h0000, 1'b0, 2); sh[wi] = d; end
        1: begin
          push_exp(16'h0000, 1'b0, 3);
          if (lane) sh[wi][15:8] = d[7:0]; else sh[wi][7:0] = d[7:0];
        end
        2: push_exp(w, 1'b0, 2);
        default: push_exp(s ? {{8{bt[7]}}, bt} : {8'h00, bt}, 1'b0, 2);
      endcase
      drive_req(op < 2, op[0], s, a, d);
      e = sb.pop_front();
      n_checks++;
      if ({lat, rd, er} !== {e.lat, e.data, e.err}) begin
        n_fail++;
        $display("FAIL random_%0d op%0d addr=%h: lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
                 i, op, a, lat, rd, er, e.lat, e.data, e.err);
      end
    end
    @(negedge Clock);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[8'h30 + 8'(i)] !== sh[i]) begin
        n_fail++;
        $display("FAIL random_mem_%0d: got %h want %h", i, mem[8'h30 + 8'(i)], sh[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_byte_loads();
    test_misaligned();
    test_top_addr();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
